// File: rtl/inst_fetch_if.sv
// Instruction-memory port: fetch unit drives chip enable and byte address,
// memory answers combinationally with the addressed word.
interface inst_fetch_if;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] data_in;

    modport master (output ce, output addr, input data_in);
    modport slave  (input ce, input addr, output data_in);
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: sequential fetch with one-cycle latency, stall hold,
// redirect on jump and a sticky halt on misaligned jump targets.
//
// state | meaning
// IDLE  | one warm-up cycle after reset, memory disabled
// FETCH | memory enabled, capture data_in at pc and advance
// STALL | memory disabled, outputs held until stall drops
// HALT  | misaligned jump seen, frozen until rst
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_if.master       imem,
    input  logic               stall,
    input  logic               jump_en,
    input  logic [31:0]        jump_addr,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    output logic               inst_valid,
    output logic               misalign,
    output logic [31:0]        fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;

    // ce comes straight from the state register so memory never sees an input glitch
    assign imem.ce   = (state == FETCH);
    assign imem.addr = (state == FETCH) ? pc : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            inst       <= 32'h0;
            inst_pc    <= 32'h0;
            inst_valid <= 1'b0;
            misalign   <= 1'b0;
            fetch_cnt  <= 32'h0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH, STALL: begin
                    if (jump_en) begin
                        inst_valid <= 1'b0;
                        if (jump_addr[1:0] != 2'b00) begin
                            misalign <= 1'b1;
                            state    <= HALT;
                        end else begin
                            pc    <= jump_addr;
                            inst  <= 32'h0;
                            state <= stall ? STALL : FETCH;
                        end
                    end else if (stall) begin
                        state <= STALL;
                    end else if (state == FETCH) begin
                        inst       <= imem.data_in;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        pc         <= pc + 32'd4;
                        fetch_cnt  <= fetch_cnt + 32'd1;
                    end else begin
                        // leaving STALL spends one edge re-enabling memory
                        state <= FETCH;
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch against a behavioural fetch model, plus
// directed scenarios and a second instance exercising a high reset PC wrap.
module tb_inst_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, jump_en;
    logic [31:0] jump_addr;
    logic [31:0] inst, inst_pc, fetch_cnt;
    logic        inst_valid, misalign;

    logic        rst2;
    logic [31:0] inst2, inst_pc2, fetch_cnt2;
    logic        inst_valid2, misalign2;

    logic [31:0] mem [0:1023];

    inst_fetch_if bus ();
    inst_fetch_if bus2 ();

    assign bus.data_in  = bus.ce  ? mem[bus.addr[11:2]]  : 32'h0;
    assign bus2.data_in = bus2.ce ? mem[bus2.addr[11:2]] : 32'h0;

    inst_fetch dut (
        .clk(clk), .rst(rst), .imem(bus), .stall(stall), .jump_en(jump_en),
        .jump_addr(jump_addr), .inst(inst), .inst_pc(inst_pc),
        .inst_valid(inst_valid), .misalign(misalign), .fetch_cnt(fetch_cnt)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
        .clk(clk), .rst(rst2), .imem(bus2), .stall(1'b0), .jump_en(1'b0),
        .jump_addr(32'h0), .inst(inst2), .inst_pc(inst_pc2),
        .inst_valid(inst_valid2), .misalign(misalign2), .fetch_cnt(fetch_cnt2)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: m_en = memory enabled this cycle, m_boot = first cycle after reset
    logic        m_en, m_boot, m_halt, m_valid, m_mis;
    logic [31:0] m_pc, m_inst, m_ipc, m_cnt;

    task automatic model_step();
        if (rst) begin
            m_en = 0; m_boot = 1; m_halt = 0; m_valid = 0; m_mis = 0;
            m_pc = 32'h0; m_inst = 0; m_ipc = 0; m_cnt = 0;
        end else if (m_halt) begin
            m_en = 0;
        end else if (m_boot) begin
            m_boot = 0; m_en = 1;
        end else if (jump_en) begin
            m_valid = 0;
            if (jump_addr % 4 != 0) begin
                m_mis = 1; m_halt = 1; m_en = 0;
            end else begin
                m_pc = jump_addr; m_inst = 0; m_en = !stall;
            end
        end else if (stall) begin
            m_en = 0;
        end else if (m_en) begin
            m_inst  = mem[(m_pc / 4) % 1024];
            m_ipc   = m_pc;
            m_valid = 1;
            m_pc    = m_pc + 4;
            m_cnt   = m_cnt + 1;
        end else begin
            m_en = 1;
        end
    endtask

    task automatic check_all();
        chk("ce",         {31'b0, bus.ce},     {31'b0, m_en});
        chk("addr",       bus.addr,            m_en ? m_pc : 32'h0);
        chk("inst",       inst,                m_inst);
        chk("inst_pc",    inst_pc,             m_ipc);
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
        chk("misalign",   {31'b0, misalign},   {31'b0, m_mis});
        chk("fetch_cnt",  fetch_cnt,           m_cnt);
    endtask

    task automatic cycle(input logic r, input logic s, input logic j, input logic [31:0] ja);
        rst = r; stall = s; jump_en = j; jump_addr = ja;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h34011100;
        mem[1] = 32'h30020020;
        mem[2] = 32'h3803FF00;
        rst = 1; stall = 0; jump_en = 0; jump_addr = 0; rst2 = 1;
        m_en = 0; m_boot = 1; m_halt = 0; m_valid = 0; m_mis = 0;
        m_pc = 0; m_inst = 0; m_ipc = 0; m_cnt = 0;

        cycle(1, 0, 0, 0);
        cycle(1, 1, 1, 32'h22);
        chk("rst_ce", {31'b0, bus.ce}, 32'h0);

        // reset release: warm-up edge then three back-to-back captures
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("r_inst0", inst, 32'h34011100);
        chk("r_pc0", inst_pc, 32'h0);
        chk("r_val0", {31'b0, inst_valid}, 32'h1);
        cycle(0, 0, 0, 0);
        chk("r_inst1", inst, 32'h30020020);
        chk("r_pc1", inst_pc, 32'h4);
        cycle(0, 0, 0, 0);
        chk("r_pc2", inst_pc, 32'h8);
        chk("r_cnt3", fetch_cnt, 32'd3);

        // three stalled cycles, one dead edge, then the next word
        repeat (3) cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        chk("st_dead_pc", inst_pc, 32'h8);
        cycle(0, 0, 0, 0);
        chk("st_next_pc", inst_pc, 32'hC);

        cycle(0, 0, 1, 32'h20);
        chk("j_val", {31'b0, inst_valid}, 32'h0);
        chk("j_inst", inst, 32'h0);
        cycle(0, 0, 0, 0);
        chk("j_pc", inst_pc, 32'h20);

        // jump while stalled lands in STALL with the new pc
        cycle(0, 1, 1, 32'h14);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("js_pc", inst_pc, 32'h14);

        cycle(0, 0, 1, 32'h22);
        for (int i = 0; i < 12; i++)
            cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h40);
        chk("halt_mis", {31'b0, misalign}, 32'h1);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("halt_resume_pc", inst_pc, 32'h0);

        for (int i = 0; i < 4000; i++) begin
            logic [31:0] ja;
            ja = $urandom;
            if ($urandom_range(0, 3) != 0) ja[1:0] = 2'b00;
            cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0, ja);
        end

        // high reset PC wraps through zero on consecutive edges
        @(negedge clk);
        rst2 = 0;
        @(negedge clk);
        chk("hi_addr", bus2.addr, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("hi_pc0", inst_pc2, 32'hFFFF_FFF8);
        chk("hi_inst0", inst2, mem[1022]);
        @(negedge clk);
        chk("hi_pc1", inst_pc2, 32'hFFFF_FFFC);
        chk("hi_inst1", inst2, mem[1023]);
        @(negedge clk);
        chk("hi_pc2", inst_pc2, 32'h0);
        chk("hi_inst2", inst2, mem[0]);
        chk("hi_cnt", fetch_cnt2, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
